// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for the multi-cycle core:
// opcodes, ALU codes, FSM states and PC source select.
package cpu_isa_pkg;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_SLT  = 6'b000010;
   localparam logic [5:0] OP_AND  = 6'b000011;
   localparam logic [5:0] OP_NOR  = 6'b000100;
   localparam logic [5:0] OP_OR   = 6'b000101;
   localparam logic [5:0] OP_XOR  = 6'b000110;
   localparam logic [5:0] OP_SLLV = 6'b000111;
   localparam logic [5:0] OP_SRAV = 6'b001000;
   localparam logic [5:0] OP_SRLV = 6'b001001;
   localparam logic [5:0] OP_ADDI = 6'b010000;
   localparam logic [5:0] OP_SUBI = 6'b010001;
   localparam logic [5:0] OP_SLTI = 6'b010010;
   localparam logic [5:0] OP_ANDI = 6'b010011;
   localparam logic [5:0] OP_LUI  = 6'b010100;
   localparam logic [5:0] OP_NORI = 6'b010101;
   localparam logic [5:0] OP_ORI  = 6'b010110;
   localparam logic [5:0] OP_XORI = 6'b010111;
   localparam logic [5:0] OP_LW   = 6'b100000;
   localparam logic [5:0] OP_SW   = 6'b100001;
   localparam logic [5:0] OP_BEQ  = 6'b110000;
   localparam logic [5:0] OP_BNE  = 6'b110001;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0011;
   localparam logic [3:0] ALU_OR  = 4'b0100;
   localparam logic [3:0] ALU_XOR = 4'b0101;
   localparam logic [3:0] ALU_NOR = 4'b0110;
   localparam logic [3:0] ALU_LUI = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRA = 4'b1001;
   localparam logic [3:0] ALU_SRL = 4'b1010;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXE  = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_ALUR, C_ALUI, C_LW, C_SW,
      C_BR, C_J, C_HALT, C_ILL
   } cls_t;

endpackage

// File: rtl/cu_decode.sv
// Static field decoder: latched opcode to ALU controls,
// operand/extension selects and instruction class.
module cu_decode
   import cpu_isa_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic [OP_W-1:0] opQ,
   output logic [3:0]      aluOp,
   output logic            aluSrcB,
   output logic            extSel,
   output logic            regOut,
   output cls_t            cls
);

   logic [5:0] opc;
   assign opc = 6'(opQ);

   always_comb begin
      aluOp   = ALU_ADD;
      aluSrcB = 1'b0;
      extSel  = 1'b0;
      regOut  = 1'b0;
      cls     = C_ILL;
      unique case (1'b1)
         (opc == OP_ADD):  begin cls = C_ALUR; aluOp = ALU_ADD; end
         (opc == OP_SUB):  begin cls = C_ALUR; aluOp = ALU_SUB; end
         (opc == OP_SLT):  begin cls = C_ALUR; aluOp = ALU_SLT; end
         (opc == OP_AND):  begin cls = C_ALUR; aluOp = ALU_AND; end
         (opc == OP_NOR):  begin cls = C_ALUR; aluOp = ALU_NOR; end
         (opc == OP_OR):   begin cls = C_ALUR; aluOp = ALU_OR;  end
         (opc == OP_XOR):  begin cls = C_ALUR; aluOp = ALU_XOR; end
         (opc == OP_SLLV): begin cls = C_ALUR; aluOp = ALU_SLL; end
         (opc == OP_SRAV): begin cls = C_ALUR; aluOp = ALU_SRA; end
         (opc == OP_SRLV): begin cls = C_ALUR; aluOp = ALU_SRL; end
         (opc == OP_ADDI): begin cls = C_ALUI; aluOp = ALU_ADD; extSel = 1'b1; end
         (opc == OP_SUBI): begin cls = C_ALUI; aluOp = ALU_SUB; extSel = 1'b1; end
         (opc == OP_SLTI): begin cls = C_ALUI; aluOp = ALU_SLT; extSel = 1'b1; end
         (opc == OP_ANDI): begin cls = C_ALUI; aluOp = ALU_AND; end
         (opc == OP_LUI):  begin cls = C_ALUI; aluOp = ALU_LUI; end
         (opc == OP_NORI): begin cls = C_ALUI; aluOp = ALU_NOR; end
         (opc == OP_ORI):  begin cls = C_ALUI; aluOp = ALU_OR;  end
         (opc == OP_XORI): begin cls = C_ALUI; aluOp = ALU_XOR; end
         (opc == OP_LW):   begin cls = C_LW; extSel = 1'b1; end
         (opc == OP_SW):   begin cls = C_SW; extSel = 1'b1; end
         (opc == OP_BEQ):  begin cls = C_BR; aluOp = ALU_SUB; extSel = 1'b1; end
         (opc == OP_BNE):  begin cls = C_BR; aluOp = ALU_SUB; extSel = 1'b1; end
         (opc == OP_J):    cls = C_J;
         (opc == OP_HALT): cls = C_HALT;
         default:          cls = C_ILL;
      endcase
      aluSrcB = (cls == C_ALUI) || (cls == C_LW) || (cls == C_SW);
      regOut  = (cls == C_ALUR);
   end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle control FSM: IF/ID/EXE/MEM/WB/HALT sequencing
// with combinational strobes from state and latched opcode.
module multi_cycle_control_unit
   import cpu_isa_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int ALUOP_W = 4,
   parameter int STATE_W = 3
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [OP_W-1:0]    op,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               PCWre,
   output logic [1:0]         PCSrc,
   output logic               IRWre,
   output logic               InsMemRW,
   output logic               ExtSel,
   output logic               ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               DataMemRW,
   output logic               DataMemEn,
   output logic               ALUM2Reg,
   output logic               RegWre,
   output logic               RegOut,
   output logic               illegal,
   output logic               halted,
   output logic [STATE_W-1:0] state_o
);

   state_t          state, nxt;
   logic [OP_W-1:0] opQ;
   logic [3:0]      decAluOp;
   logic            decSrcB, decExt, decRegOut;
   cls_t            cls;
   logic            take;

   cu_decode #(.OP_W(OP_W)) uDecode (
      .opQ    (opQ),
      .aluOp  (decAluOp),
      .aluSrcB(decSrcB),
      .extSel (decExt),
      .regOut (decRegOut),
      .cls    (cls)
   );

   assign take = (6'(opQ) == OP_BNE) ? !zero : zero;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state <= S_IF;
         opQ   <= '0;
      end else begin
         state <= nxt;
         if (state == S_IF) opQ <= op;
      end
   end

   always_comb begin
      nxt       = state;
      PCWre     = 1'b0;
      PCSrc     = PC_SEQ;
      IRWre     = 1'b0;
      InsMemRW  = 1'b0;
      ExtSel    = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = '0;
      DataMemRW = 1'b0;
      DataMemEn = 1'b0;
      ALUM2Reg  = 1'b0;
      RegWre    = 1'b0;
      RegOut    = 1'b0;
      illegal   = 1'b0;
      halted    = 1'b0;
      unique case (state)
         S_IF: begin
            IRWre    = 1'b1;
            InsMemRW = 1'b1;
            nxt      = S_ID;
         end
         S_ID: begin
            nxt = S_EXE;
            if (cls == C_J) begin
               PCWre = 1'b1;
               PCSrc = PC_JMP;
               nxt   = S_IF;
            end else if (cls == C_HALT) begin
               nxt = S_HALT;
            end else if (cls == C_ILL) begin
               illegal = 1'b1;
               PCWre   = 1'b1;
               nxt     = S_IF;
            end
         end
         S_EXE: begin
            ALUSrcB = decSrcB;
            ExtSel  = decExt;
            ALUOp   = ALUOP_W'(decAluOp);
            if (cls == C_BR) begin
               PCWre = 1'b1;
               PCSrc = take ? PC_BR : PC_SEQ;
               nxt   = S_IF;
            end else if (cls == C_LW || cls == C_SW) begin
               nxt = S_MEM;
            end else begin
               nxt = S_WB;
            end
         end
         S_MEM: begin
            DataMemEn = 1'b1;
            DataMemRW = (cls == C_SW);
            if (mem_ready) begin
               if (cls == C_SW) begin
                  PCWre = 1'b1;
                  nxt   = S_IF;
               end else begin
                  nxt = S_WB;
               end
            end
         end
         S_WB: begin
            RegWre   = 1'b1;
            PCWre    = 1'b1;
            ALUM2Reg = (cls == C_LW);
            RegOut   = decRegOut;
            nxt      = S_IF;
         end
         S_HALT: halted = 1'b1;
         default: nxt = S_IF;
      endcase
      // Reset dominates every strobe, including the IF fetch strobes
      if (Reset) begin
         nxt      = S_IF;
         PCWre    = 1'b0;
         PCSrc    = PC_SEQ;
         IRWre    = 1'b0;
         InsMemRW = 1'b0;
         ExtSel   = 1'b0;
         ALUSrcB  = 1'b0;
         ALUOp    = '0;
         DataMemRW = 1'b0;
         DataMemEn = 1'b0;
         ALUM2Reg = 1'b0;
         RegWre   = 1'b0;
         RegOut   = 1'b0;
         illegal  = 1'b0;
         halted   = 1'b0;
      end
   end

   assign state_o = STATE_W'(state);

endmodule

// File: doc/multi_cycle_control_unit.md
MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 SHALL have parameter OP_W, default 6, opcode width.
REQ-002 SHALL have parameter ALUOP_W, default 4, ALU operation code width.
REQ-003 SHALL have parameter STATE_W, default 3, width of the state_o debug port.
REQ-004 SHALL have ports, one per line as follows:
  CLK  input  1  single clock, all state changes on rising edge.
  Reset  input  1  asynchronous, active-high reset.
  op  input  OP_W  opcode field of the instruction register.
  zero  input  1  ALU zero flag, valid in EXE.
  mem_ready  input  1  data memory done, valid in MEM.
  PCWre  output  1  PC write enable.
  PCSrc  output  2  00 PC+4, 01 branch target, 10 jump target.
  IRWre  output  1  instruction register write enable.
  InsMemRW  output  1  instruction memory read strobe.
  ExtSel  output  1  1 sign-extend, 0 zero-extend.
  ALUSrcB  output  1  1 immediate, 0 register.
  ALUOp  output  ALUOP_W  ALU operation.
  DataMemRW  output  1  1 write, 0 read.
  DataMemEn  output  1  data memory access strobe.
  ALUM2Reg  output  1  1 memory data, 0 ALU result to register.
  RegWre  output  1  register file write enable.
  RegOut  output  1  1 rd, 0 rt as destination.
  illegal  output  1  one-cycle pulse on undefined opcode.
  halted  output  1  level, core stopped.
  state_o  output  STATE_W  current state encoding.

Function
REQ-005 SHALL implement states IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5.
REQ-006 SHALL latch op into op_q on the IF->ID edge; all later decode SHALL use op_q.
REQ-007 IF: IRWre=1, InsMemRW=1, all other strobes 0; next state ID.
REQ-008 ID: J (6'b111000) -> PCWre=1, PCSrc=10, next IF; HALT (6'b111111) -> next HALT; undefined opcode -> illegal=1, PCWre=1, PCSrc=00, next IF; otherwise next EXE.
REQ-009 EXE: ALUSrcB, ExtSel and ALUOp SHALL be driven from the op_q decode; ALU-class ops -> WB; LW/SW -> MEM; BEQ/BNE -> PCWre=1, PCSrc=01 when the condition holds (BEQ zero=1, BNE zero=0), else 00, next IF.
REQ-010 MEM: DataMemEn=1, DataMemRW=1 for SW and 0 for LW; state SHALL hold MEM while mem_ready=0.
REQ-011 MEM with mem_ready=1: SW -> PCWre=1, PCSrc=00, next IF; LW -> next WB.
REQ-012 WB: RegWre=1, PCWre=1, PCSrc=00; ALUM2Reg=1 only for LW; RegOut=1 for register-register ops, 0 for immediate ops and LW.
REQ-013 HALT: halted=1, all strobes 0, held until Reset.
REQ-014 ALU field decode SHALL keep the team ISA: ADD/ADDI/LW/SW ADD; SUB/SUBI/BEQ/BNE SUB; SLT(I) SLT; AND(I) AND; LUI LUI; NOR(I) NOR; OR(I) OR; XOR(I) XOR; SLLV SLL; SRAV SRA; SRLV SRL.
REQ-015 ExtSel=1 for ADDI, SUBI, SLTI, LW, SW, BEQ, BNE; 0 otherwise.
REQ-016 Outputs SHALL be combinational from state, op_q, zero and mem_ready; PCWre SHALL be high in exactly one cycle per retired instruction.
REQ-017 Cycle counts: ALU 4, LW 5+wait, SW 4+wait, branch 3, J 2.

Reset
REQ-018 Reset asserted SHALL force state to IF and op_q to 0 immediately, independent of CLK.
REQ-019 While Reset=1 every output SHALL be 0, including IRWre and InsMemRW, and state_o SHALL be 0.
REQ-020 Reset asserted mid-instruction, including MEM wait and HALT, SHALL abandon it with no PCWre or RegWre pulse.

Structure
REQ-021 Opcode constants, ALU codes, the state enumeration and the PCSrc encodings SHALL live in shared package cpu_isa_pkg.
REQ-022 The op_q to static-field decoder SHALL be sub-module cu_decode, outputting ALUOp, ALUSrcB, ExtSel, RegOut and instruction class.

Verification
REQ-023 ADD (6'b000000) -> states 0,1,2,4,0; RegWre=1 and RegOut=1 in WB only; ALUOp=0000.
REQ-024 BEQ, zero=1 -> PCSrc=01 and PCWre=1 in EXE, back in IF on cycle 4; BNE with zero=1 -> PCSrc=00.
REQ-025 LW, mem_ready low 3 cycles -> MEM held 4 cycles, DataMemRW=0, then WB with ALUM2Reg=1, 8 cycles total.
REQ-026 op=6'b011111 -> illegal pulse in ID only, no RegWre, return to IF.
REQ-027 HALT -> halted=1 indefinitely; Reset pulse -> state_o=0, halted=0, fetch resumes.
REQ-028 Reset asserted during SW MEM wait -> outputs 0 in the same cycle, no DataMemRW=1 after release.
